axiwr_burst_sched: RTL
======================

Name: axiwr_burst_sched

Overview:
- Sequencer in front of the RAM-to-AXI write engine (ap_start/ap_done controlled, reads RAM from address 0 upward, writes I_len beats at I_base_addr).
- Splits one large output-buffer write (arbitrary beat count, arbitrary RAM start) into engine segments:
  - each segment is at most C_MAX_BURST beats;
  - no segment crosses a 4 KB AXI boundary.
- Drives the engine's start/address/length, relocates the engine's RAM read address, and presents an HLS-style ap handshake to the main process.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, AXI byte address width
- C_M_AXI_DATA_WIDTH, 128, AXI data width; BYTES = C_M_AXI_DATA_WIDTH/8 per beat
- C_RAM_ADDR_WIDTH, 10, output-buffer RAM address width; also the engine length width
- C_TOTAL_LEN_WIDTH, 16, total transfer length width, in beats
- C_MAX_BURST, 256, maximum beats per segment; must be ≤ 2^C_RAM_ADDR_WIDTH-1 and ≤ 4096/BYTES

Ports:
- I_clk  in  1  single clock
- I_rst  in  1  synchronous reset, active high
- I_ap_start  in  1  level; sampled only in IDLE
- O_ap_done  out  1  one-cycle pulse at transfer end
- O_ap_idle  out  1  high only in IDLE
- O_ap_ready  out  1  pulse coincident with O_ap_done
- I_base_addr  in  C_M_AXI_ADDR_WIDTH  DDR byte start address
- I_total_len  in  C_TOTAL_LEN_WIDTH  total beats
- I_ram_base  in  C_RAM_ADDR_WIDTH  RAM word holding beat 0
- O_eng_start  out  1  engine ap_start, held until I_eng_done
- I_eng_done  in  1  engine ap_done pulse
- O_eng_base_addr  out  C_M_AXI_ADDR_WIDTH  segment byte address
- O_eng_len  out  C_RAM_ADDR_WIDTH  segment beats
- I_eng_raddr  in  C_RAM_ADDR_WIDTH  engine RAM read address (segment-relative)
- O_ram_raddr  out  C_RAM_ADDR_WIDTH  physical RAM read address
- O_seg_cnt  out  C_TOTAL_LEN_WIDTH  segments completed in current transfer

Behaviour:
- Clock and reset:
  - One clock, I_clk.
  - Reset I_rst is synchronous, active high.
  - On reset: state=IDLE; O_eng_start, O_ap_done, O_ap_ready = 0; O_ap_idle=1; O_seg_cnt, O_eng_base_addr, O_eng_len = 0.
  - Reset mid-transfer aborts immediately. The engine self-clears when its start drops.
- FSM: IDLE, CALC, RUN, DONE.
- IDLE:
  - I_ap_start=1 latches base address (low log2(BYTES) bits forced to 0), I_total_len → remaining, I_ram_base → seg_ram_base.
  - Clears O_seg_cnt; next state is CALC.
  - If start stays high after DONE, a new transfer begins (ap_ctrl_hs semantics).
- CALC (1 cycle):
  - remaining==0 → DONE.
  - Otherwise seg = min(remaining, C_MAX_BURST, (4096 - addr[11:0])/BYTES).
  - Register O_eng_len=seg and O_eng_base_addr=addr; next state is RUN.
- RUN:
  - O_eng_start=1 for every cycle in RUN.
  - On I_eng_done: addr += seg*BYTES; remaining -= seg; seg_ram_base += seg (mod 2^C_RAM_ADDR_WIDTH); O_seg_cnt += 1; next state is CALC.
  - O_eng_start is therefore low for exactly one cycle (CALC) between segments, which the engine requires to reset.
- DONE (1 cycle): O_ap_done=O_ap_ready=1; next state is IDLE.
- Latency:
  - Start sampled at cycle 0 → O_eng_start high at cycle 2.
  - Last I_eng_done at cycle n → O_ap_done at cycle n+2.
  - Zero length → O_ap_done at cycle 2, and O_eng_start never rises.
- Abort: I_ap_start low in CALC or RUN returns to IDLE next cycle with O_eng_start=0 and no done pulse. I_eng_done outside RUN is ignored.
- O_ram_raddr = seg_ram_base + I_eng_raddr, combinational, truncated to C_RAM_ADDR_WIDTH (wraps).
- Arithmetic: address arithmetic wraps at 2^C_M_AXI_ADDR_WIDTH; no overflow flag.
- 4 KB cap: beats-to-boundary is ≥1 always, since the address is beat-aligned.

Test Plan:
- Three-segment split (defaults): base 0x0000_0000, total 600, ram_base 0.
  - Required segments: (0x0000,256), (0x1000,256), (0x2000,88), with seg_ram_base 0, 256, 512.
  - O_seg_cnt ends at 3; one O_ap_done pulse, 2 cycles after the 3rd I_eng_done.
- 4 KB crossing: base 0x0000_0F00, total 20.
  - Required segments: (0x0F00,16) then (0x1000,4).
  - O_eng_start low exactly 1 cycle between them.
- Zero length: total 0, start at cycle 0.
  - O_ap_done/O_ap_ready high at cycle 2 only, O_eng_start never 1, O_ap_idle=1 at cycle 3.
- RAM wrap: ram_base 1000, total 100, I_eng_raddr=30.
  - O_ram_raddr=6; after the segment, the next seg_ram_base is 76.
- Abort and reset:
  - Drop I_ap_start in RUN → O_eng_start=0 next cycle, state IDLE, no done.
  - Assert I_rst during RUN of segment 2 → all outputs at reset values next cycle; a fresh transfer of 20 beats then completes normally.
- Back-to-back: hold I_ap_start high across DONE.
  - Second transfer starts from IDLE with O_seg_cnt cleared and inputs re-latched.

Source files
------------

// File: rtl/axiwr_burst_sched_if.sv
// Handshake and bus bundle between the main process, the scheduler and
// the RAM-to-AXI write engine.
interface axiwr_burst_sched_if #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_RAM_ADDR_WIDTH   = 10,
  parameter int C_TOTAL_LEN_WIDTH  = 16
);
  logic                          I_ap_start;
  logic                          O_ap_done;
  logic                          O_ap_idle;
  logic                          O_ap_ready;
  logic [C_M_AXI_ADDR_WIDTH-1:0] I_base_addr;
  logic [C_TOTAL_LEN_WIDTH-1:0]  I_total_len;
  logic [C_RAM_ADDR_WIDTH-1:0]   I_ram_base;
  logic                          O_eng_start;
  logic                          I_eng_done;
  logic [C_M_AXI_ADDR_WIDTH-1:0] O_eng_base_addr;
  logic [C_RAM_ADDR_WIDTH-1:0]   O_eng_len;
  logic [C_RAM_ADDR_WIDTH-1:0]   I_eng_raddr;
  logic [C_RAM_ADDR_WIDTH-1:0]   O_ram_raddr;
  logic [C_TOTAL_LEN_WIDTH-1:0]  O_seg_cnt;

  modport slave (
    input  I_ap_start, I_base_addr, I_total_len, I_ram_base,
    input  I_eng_done, I_eng_raddr,
    output O_ap_done, O_ap_idle, O_ap_ready, O_eng_start,
    output O_eng_base_addr, O_eng_len, O_ram_raddr, O_seg_cnt
  );

  modport master (
    output I_ap_start, I_base_addr, I_total_len, I_ram_base,
    output I_eng_done, I_eng_raddr,
    input  O_ap_done, O_ap_idle, O_ap_ready, O_eng_start,
    input  O_eng_base_addr, O_eng_len, O_ram_raddr, O_seg_cnt
  );
endinterface

// File: rtl/axiwr_burst_sched.sv
// Splits one output-buffer write into engine segments capped by burst
// size and 4 KB boundaries, relocating the engine's RAM read address.
module axiwr_burst_sched #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 128,
  parameter int C_RAM_ADDR_WIDTH   = 10,
  parameter int C_TOTAL_LEN_WIDTH  = 16,
  parameter int C_MAX_BURST        = 256
) (
  input logic                I_clk,
  input logic                I_rst,
  axiwr_burst_sched_if.slave bus
);
  localparam int AW    = C_M_AXI_ADDR_WIDTH;
  localparam int RW    = C_RAM_ADDR_WIDTH;
  localparam int TW    = C_TOTAL_LEN_WIDTH;
  localparam int BYTES = C_M_AXI_DATA_WIDTH / 8;
  localparam int LB    = $clog2(BYTES);

  typedef enum logic [1:0] {
    S_IDLE, S_CALC, S_RUN, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] eng_addr_q, eng_addr_d;
  logic [TW-1:0] rem_q, rem_d;
  logic [TW-1:0] seg_cnt_q, seg_cnt_d;
  logic [RW-1:0] rbase_q, rbase_d;
  logic [RW-1:0] eng_len_q, eng_len_d;
  logic          eng_start_q, eng_start_d;
  logic          done_q, done_d;
  logic          idle_q, idle_d;
  logic [12:0]   room;
  logic [TW-1:0] seg;

  // Beats left before the next 4 KB page; never zero for aligned addr.
  always_comb begin
    room = (13'd4096 - {1'b0, addr_q[11:0]}) >> LB;
    seg  = rem_q;
    if (seg > TW'(C_MAX_BURST)) seg = TW'(C_MAX_BURST);
    if (seg > TW'(room))        seg = TW'(room);
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    eng_addr_d = eng_addr_q;
    rem_d      = rem_q;
    seg_cnt_d  = seg_cnt_q;
    rbase_d    = rbase_q;
    eng_len_d  = eng_len_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.I_ap_start) begin
          addr_d    = bus.I_base_addr & ~AW'(BYTES - 1);
          rem_d     = bus.I_total_len;
          rbase_d   = bus.I_ram_base;
          seg_cnt_d = '0;
          state_d   = S_CALC;
        end
      end
      S_CALC: begin
        if (!bus.I_ap_start) begin
          state_d = S_IDLE;
        end else if (rem_q == '0) begin
          state_d = S_DONE;
        end else begin
          eng_len_d  = RW'(seg);
          eng_addr_d = addr_q;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        if (!bus.I_ap_start) begin
          state_d = S_IDLE;
        end else if (bus.I_eng_done) begin
          addr_d    = addr_q + (AW'(eng_len_q) << LB);
          rem_d     = rem_q - TW'(eng_len_q);
          rbase_d   = rbase_q + eng_len_q;
          seg_cnt_d = seg_cnt_q + TW'(1);
          state_d   = S_CALC;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    eng_start_d = (state_d == S_RUN);
    done_d      = (state_d == S_DONE);
    idle_d      = (state_d == S_IDLE);
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      eng_addr_q  <= '0;
      rem_q       <= '0;
      seg_cnt_q   <= '0;
      rbase_q     <= '0;
      eng_len_q   <= '0;
      eng_start_q <= 1'b0;
      done_q      <= 1'b0;
      idle_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      eng_addr_q  <= eng_addr_d;
      rem_q       <= rem_d;
      seg_cnt_q   <= seg_cnt_d;
      rbase_q     <= rbase_d;
      eng_len_q   <= eng_len_d;
      eng_start_q <= eng_start_d;
      done_q      <= done_d;
      idle_q      <= idle_d;
    end
  end

  assign bus.O_eng_start     = eng_start_q;
  assign bus.O_ap_done       = done_q;
  assign bus.O_ap_ready      = done_q;
  assign bus.O_ap_idle       = idle_q;
  assign bus.O_eng_base_addr = eng_addr_q;
  assign bus.O_eng_len       = eng_len_q;
  assign bus.O_seg_cnt       = seg_cnt_q;
  assign bus.O_ram_raddr     = rbase_q + bus.I_eng_raddr;
endmodule
